// File: rtl/mvm_load_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module : mvm_seq_pkg
// Brief  : Shared state encoding and sizing helpers for mvm_load_sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
package mvm_seq_pkg;

    localparam int unsigned K_DEFAULT = 32;
    localparam int unsigned MAT_WORDS = K_DEFAULT * K_DEFAULT;
    localparam int unsigned VEC_BASE  = MAT_WORDS;
    localparam int unsigned VEC_WORDS = K_DEFAULT;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        RST  = 4'd1,
        LDM  = 4'd2,
        MAT  = 4'd3,
        LDV  = 4'd4,
        VEC  = 4'd5,
        STR  = 4'd6,
        WAIT = 4'd7,
        TO   = 4'd8
    } state_t;

    function automatic int mat_words(input int k);
        return k * k;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mvm_load_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : mvm_load_sequencer_if
// Brief  : Host, word-memory and MVM-core signals of the load sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
interface mvm_load_sequencer_if #(
    parameter int B      = 32,
    parameter int ADDR_W = 11,
    parameter int CNT_W  = 32
);
    logic              go;
    logic              busy;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [B-1:0]      mem_rd_data;
    logic              mvm_reset;
    logic              mvm_loadm;
    logic              mvm_loadv;
    logic              mvm_start;
    logic [B-1:0]      mvm_data;
    logic              mvm_done;
    logic              job_done;
    logic              timeout;
    logic [CNT_W-1:0]  cycles;

    modport master (
        input  go, mem_rd_data, mvm_done,
        output busy, mem_rd_en, mem_addr, mvm_reset, mvm_loadm, mvm_loadv,
               mvm_start, mvm_data, job_done, timeout, cycles
    );

    modport slave (
        output go, mem_rd_data, mvm_done,
        input  busy, mem_rd_en, mem_addr, mvm_reset, mvm_loadm, mvm_loadv,
               mvm_start, mvm_data, job_done, timeout, cycles
    );
endinterface
`default_nettype wire

// File: rtl/mvm_load_sequencer_timer.sv
`default_nettype none
// ============================================================================
// Module : mvm_cycle_timer
// Brief  : Saturating start-to-done counter with timeout compare.
// Rev    : 1.0 - initial release
// ============================================================================
module mvm_cycle_timer #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count_next,
    output logic             o_expired
);
    localparam logic [CNT_W-1:0] c_MAX     = '1;
    localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;

    // Inclusive count of the current cycle, i.e. what the register will hold next.
    assign w_count_next = (r_count == c_MAX) ? c_MAX : r_count + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= CNT_W'(1);
        end else if (i_en) begin
            r_count <= w_count_next;
        end
    end

    assign o_count_next = w_count_next;
    assign o_expired    = (w_count_next >= c_TIMEOUT);

endmodule
`default_nettype wire

// File: rtl/mvm_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module : mvm_load_sequencer
// Brief  : Replays a K*K matrix and K vector from word memory into an MVM core
//          and measures the core's start-to-done latency.
// Rev    : 1.0 - initial release
// ============================================================================
module mvm_load_sequencer
    import mvm_seq_pkg::*;
#(
    parameter int K       = 32,
    parameter int B       = 32,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 65535
) (
    input  logic                 clk,
    input  logic                 reset,
    mvm_load_sequencer_if.master bus
);
    localparam int c_MAT_WORDS = mat_words(K);
    localparam int c_VEC_WORDS = K;
    localparam int ADDR_W      = $clog2(c_MAT_WORDS + c_VEC_WORDS);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_word;
    logic              r_job_done;
    logic              r_timeout;
    logic [CNT_W-1:0]  r_cycles;

    logic              w_mat_last;
    logic              w_vec_last;
    logic              w_accept;
    logic              w_done;
    logic              w_rd_en;
    logic [ADDR_W-1:0] w_addr;
    logic              w_mvm_reset;
    logic              w_mvm_loadm;
    logic              w_mvm_loadv;
    logic              w_mvm_start;
    logic [B-1:0]      w_data;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_expired;

    assign w_mat_last = (r_word == ADDR_W'(c_MAT_WORDS - 1));
    assign w_vec_last = (r_word == ADDR_W'(c_VEC_WORDS - 1));
    // A go landing on the job_done cycle is dropped so the host sees a clean handoff.
    assign w_accept   = (r_state == IDLE) && bus.go && !r_job_done;
    assign w_done     = (r_state == WAIT) && bus.mvm_done;

    mvm_cycle_timer #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk          (clk),
        .rst          (reset),
        .i_load       (r_state == STR),
        .i_en         (r_state == WAIT),
        .o_count_next (w_cnt_next),
        .o_expired    (w_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_rd_en     = 1'b0;
        w_addr      = '0;
        w_mvm_reset = 1'b0;
        w_mvm_loadm = 1'b0;
        w_mvm_loadv = 1'b0;
        w_mvm_start = 1'b0;
        w_data      = '0;
        case (r_state)
            IDLE: if (w_accept) w_next = RST;
            RST: begin
                w_mvm_reset = 1'b1;
                w_next      = LDM;
            end
            LDM: begin
                w_mvm_loadm = 1'b1;
                w_rd_en     = 1'b1;
                w_next      = MAT;
            end
            // Read one word ahead so the registered memory output lines up with this cycle.
            MAT: begin
                w_data  = bus.mem_rd_data;
                w_rd_en = !w_mat_last;
                w_addr  = w_mat_last ? '0 : r_word + ADDR_W'(1);
                if (w_mat_last) w_next = LDV;
            end
            LDV: begin
                w_mvm_loadv = 1'b1;
                w_rd_en     = 1'b1;
                w_addr      = ADDR_W'(c_MAT_WORDS);
                w_next      = VEC;
            end
            VEC: begin
                w_data  = bus.mem_rd_data;
                w_rd_en = !w_vec_last;
                w_addr  = w_vec_last ? '0 : ADDR_W'(c_MAT_WORDS) + r_word + ADDR_W'(1);
                if (w_vec_last) w_next = STR;
            end
            STR: begin
                w_mvm_start = 1'b1;
                w_next      = WAIT;
            end
            WAIT: begin
                if (bus.mvm_done) begin
                    w_next = IDLE;
                end else if (w_expired) begin
                    w_next = TO;
                end
            end
            TO:      w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word <= '0;
        end else if ((r_state == MAT && !w_mat_last) || (r_state == VEC && !w_vec_last)) begin
            r_word <= r_word + ADDR_W'(1);
        end else begin
            r_word <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_job_done <= 1'b0;
            r_timeout  <= 1'b0;
            r_cycles   <= '0;
        end else begin
            r_job_done <= w_done || (r_state == TO);
            if (w_done) begin
                r_cycles <= w_cnt_next;
            end else if (r_state == TO) begin
                r_cycles <= CNT_W'(TIMEOUT);
            end
            if (r_state == TO) begin
                r_timeout <= 1'b1;
            end else if (w_accept) begin
                r_timeout <= 1'b0;
            end
        end
    end

    assign bus.busy      = (r_state != IDLE);
    assign bus.mem_rd_en = w_rd_en;
    assign bus.mem_addr  = w_addr;
    assign bus.mvm_reset = w_mvm_reset;
    assign bus.mvm_loadm = w_mvm_loadm;
    assign bus.mvm_loadv = w_mvm_loadv;
    assign bus.mvm_start = w_mvm_start;
    assign bus.mvm_data  = w_data;
    assign bus.job_done  = r_job_done;
    assign bus.timeout   = r_timeout;
    assign bus.cycles    = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_mvm_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_mvm_load_sequencer
// Brief  : Self-checking bench: memory and core models, protocol monitor, job table.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_mvm_load_sequencer;
    localparam int K       = 32;
    localparam int B       = 32;
    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 100;
    localparam int WORDS   = K * K + K;
    localparam int ADDR_W  = $clog2(WORDS);

    typedef struct {
        int delay;      // done this many cycles after start, 0 = never
        bit spur;       // extra done pulse in the vector phase
        int hold;       // cycles go is held
        int poke;       // cycle offset of an extra go pulse, 0 = none
        bit go_at_jd;   // raise go in the job_done cycle
        bit ramp;       // mem[i] = i instead of random words
        int exp_cycles;
        bit exp_to;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   last_cycles = 0;
    int   done_delay = 0;
    bit   spur_en = 1'b0;
    int   since = 0;
    int   vsince = 0;
    logic [B-1:0] mem [WORDS];
    vec_t tbl [8];

    mvm_load_sequencer_if #(.B(B), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    mvm_load_sequencer #(.K(K), .B(B), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];
    end

    // Core model: done a fixed number of cycles after start, optional stray done after loadv.
    always @(posedge clk) begin
        if (bus.mvm_start) since = 1; else if (since > 0) since = since + 1;
        if (bus.mvm_loadv) vsince = 1; else if (vsince > 0) vsince = vsince + 1;
        bus.mvm_done <= (done_delay > 0 && since == done_delay) || (spur_en && vsince == 10);
    end

    // Protocol monitor: per-job tallies, restarted whenever a go is accepted by the rules.
    int m_nrst, m_nldm, m_nldv, m_nstr, m_seq, m_derr, m_nz, m_multi;
    int m_rd, m_aerr, m_win, m_idx, m_rdnext, m_start_cyc;
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.go && !bus.busy && !bus.job_done) begin
                m_nrst = 0; m_nldm = 0; m_nldv = 0; m_nstr = 0; m_seq = 0; m_derr = 0;
                m_nz = 0; m_multi = 0; m_rd = 0; m_aerr = 0; m_win = 0; m_idx = 0;
                m_rdnext = 0; m_start_cyc = 0;
            end
            if (int'(bus.mvm_reset) + int'(bus.mvm_loadm) + int'(bus.mvm_loadv) + int'(bus.mvm_start) > 1)
                m_multi++;
            if (m_win > 0) begin
                if (m_idx < WORDS && bus.mvm_data !== mem[m_idx]) m_derr++;
                m_idx++;
                m_win--;
            end else if (bus.mvm_data !== '0) begin
                m_nz++;
            end
            if (m_seq < 100000) begin
                if (bus.mvm_reset) m_seq = m_seq * 10 + 1;
                if (bus.mvm_loadm) m_seq = m_seq * 10 + 2;
                if (bus.mvm_loadv) m_seq = m_seq * 10 + 3;
                if (bus.mvm_start) m_seq = m_seq * 10 + 4;
            end
            if (bus.mvm_reset) m_nrst++;
            if (bus.mvm_loadm) begin m_nldm++; m_win = K * K; m_idx = 0; end
            if (bus.mvm_loadv) begin m_nldv++; m_win = K; m_idx = K * K; end
            if (bus.mvm_start) begin m_nstr++; m_start_cyc = cyc; end
            if (bus.mem_rd_en) begin
                if (int'(bus.mem_addr) != m_rdnext) m_aerr++;
                m_rdnext++;
                m_rd++;
            end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_cycles(input int d, output bit to);
        to = !(d >= 1 && d + 1 <= TIMEOUT);
        return to ? TIMEOUT : d + 1;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},     bus.busy, 0);
        check({tag, "_rd_en"},    bus.mem_rd_en, 0);
        check({tag, "_addr"},     bus.mem_addr, 0);
        check({tag, "_pulses"},   {bus.mvm_reset, bus.mvm_loadm, bus.mvm_loadv, bus.mvm_start}, 0);
        check({tag, "_data"},     bus.mvm_data, 0);
        check({tag, "_job_done"}, bus.job_done, 0);
        check({tag, "_timeout"},  bus.timeout, 0);
        check({tag, "_cycles"},   bus.cycles, 0);
    endtask

    task automatic run_job(input vec_t v);
        int  n0;
        int  jd;
        bit  seen;
        for (int i = 0; i < WORDS; i++) mem[i] = v.ramp ? 32'(i) : $urandom();
        done_delay = v.delay;
        spur_en    = v.spur;
        @(negedge clk);
        bus.go = 1'b1;
        n0 = cyc;
        @(negedge clk);
        check("busy_after_go", bus.busy, 1);
        check("timeout_cleared", bus.timeout, 0);
        check("cycles_held", bus.cycles, last_cycles);
        for (int i = 1; i < v.hold; i++) @(negedge clk);
        bus.go = 1'b0;
        if (v.poke > 0) begin
            while (cyc < n0 + v.poke) @(negedge clk);
            bus.go = 1'b1;
            @(negedge clk);
            bus.go = 1'b0;
            check("busy_during_poke", bus.busy, 1);
        end
        seen = 1'b0;
        jd   = 0;
        for (int t = 0; t < 3000 && !seen; t++) begin
            @(negedge clk);
            if (bus.job_done) begin
                seen = 1'b1;
                jd   = cyc;
            end
        end
        check("job_done_seen", seen, 1);
        if (seen) begin
            check("busy_at_job_done", bus.busy, 0);
            check("cycles", bus.cycles, v.exp_cycles);
            check("timeout", bus.timeout, v.exp_to);
            if (v.go_at_jd) bus.go = 1'b1;
            @(negedge clk);
            bus.go = 1'b0;
            check("job_done_single", bus.job_done, 0);
            repeat (2) @(negedge clk);
            check("no_restart", bus.busy, 0);
        end
        check("n_reset", m_nrst, 1);
        check("n_loadm", m_nldm, 1);
        check("n_loadv", m_nldv, 1);
        check("n_start", m_nstr, 1);
        check("pulse_order", m_seq, 1234);
        check("data_err", m_derr, 0);
        check("nonzero_outside", m_nz, 0);
        check("multi_pulse", m_multi, 0);
        check("rd_count", m_rd, WORDS);
        check("rd_addr_err", m_aerr, 0);
        check("str_latency", m_start_cyc - n0, 4 + K * K + K);
        if (!v.exp_to && seen) check("done_to_job_done", jd - (m_start_cyc + v.delay), 1);
        last_cycles = v.exp_cycles;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   d;
        int   ec;
        bit   eto;
        vec_t v;
        int   n0;
        int   jd_cnt;

        reset  = 1'b1;
        bus.go = 1'b0;
        for (int i = 0; i < WORDS; i++) mem[i] = '0;

        tbl[0] = '{40, 1'b0, 1, 0,   1'b0, 1'b1, 41,  1'b0};
        tbl[1] = '{1,  1'b1, 1, 0,   1'b0, 1'b0, 2,   1'b0};
        tbl[2] = '{0,  1'b0, 1, 0,   1'b0, 1'b0, 100, 1'b1};
        tbl[3] = '{99, 1'b0, 1, 0,   1'b0, 1'b0, 100, 1'b0};
        tbl[4] = '{100,1'b0, 1, 0,   1'b0, 1'b0, 100, 1'b1};
        tbl[5] = '{5,  1'b0, 5, 200, 1'b0, 1'b0, 6,   1'b0};
        for (int r = 6; r < 8; r++) begin
            d  = int'($urandom_range(1, 130));
            ec = model_cycles(d, eto);
            tbl[r] = '{d, 1'b0, 1, 0, (r == 6), 1'b0, ec, eto};
        end

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int r = 0; r < 8; r++) run_job(tbl[r]);

        // Abort in the middle of the matrix stream.
        for (int i = 0; i < WORDS; i++) mem[i] = $urandom();
        done_delay = 0;
        spur_en    = 1'b0;
        @(negedge clk);
        bus.go = 1'b1;
        n0 = cyc;
        @(negedge clk);
        bus.go = 1'b0;
        while (cyc < n0 + 3 + 100) @(negedge clk);
        check("mat_word100", bus.mvm_data, mem[100]);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("midreset");
        reset = 1'b0;
        jd_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.job_done || bus.busy) jd_cnt++;
        end
        check("idle_after_abort", jd_cnt, 0);
        last_cycles = 0;
        v = '{40, 1'b0, 1, 0, 1'b0, 1'b1, 41, 1'b0};
        run_job(v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
